return_address_stack: RTL and testbench
=======================================

Name: return_address_stack

Overview:
- Circular LIFO of link addresses for the fetch stage.
- Consumes the 11-bit next-PC value that the writeback stage writes to the link register on JAL/JALR.
- Supplies the predicted target for a JR through $ra, so fetch redirects without waiting for the register-file read.
- Sits beside the PC unit; the register-file path remains the architectural source, and this block is only a predictor.

Parameters:
ADDR_WIDTH, 11, width of a PC/link address (matches the instruction-memory address width)
DEPTH, 8, number of stack entries; must be a power of two, 2..64
PTR_WIDTH, $clog2(DEPTH), width of the top pointer

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-low reset
stall  input  1  pipeline hold; when 1, push/pop/flush are ignored and state holds
flush  input  1  clear stack (exception or pipeline restart)
push  input  1  JAL or JALR retiring; pushes push_addr
push_addr  input  ADDR_WIDTH  next-PC value written to the link register
pop  input  1  JR $ra fetched; consumes top entry
actual_target  input  ADDR_WIDTH  resolved JR target from register file
resolve  input  1  actual_target valid this cycle (JR in execute)
top_addr  output  ADDR_WIDTH  current top entry (prediction), combinational from state
top_valid  output  1  stack non-empty
depth_count  output  PTR_WIDTH+1  number of valid entries, 0..DEPTH
overflow  output  1  registered one-cycle pulse: push discarded the oldest entry
mispredict  output  1  registered one-cycle pulse: resolved target differed from the recorded prediction

Behaviour:
- Reset (reset=0, asynchronous):
  - top pointer = 0 and depth_count = 0.
  - top_valid = 0 and top_addr = 0.
  - overflow = 0 and mispredict = 0.
  - All entries are cleared to 0.
- State updates on the rising clock edge only when stall=0.
- Priority within a cycle: flush > (push & pop) > push > pop.
- flush:
  - depth_count becomes 0 and the pointer becomes 0.
  - Entries are not required to be cleared.
  - Any pending prediction record is dropped; no mispredict fires from it.
- push only:
  - pointer increments mod DEPTH; entry[pointer+1] <= push_addr.
  - depth_count saturates at DEPTH.
  - If depth_count was already DEPTH, the oldest entry is overwritten (wrap-around) and overflow pulses the next cycle.
- pop only:
  - If depth_count > 0: pointer decrements mod DEPTH and depth_count decrements.
  - If depth_count = 0 (underflow): no state change and top_addr reads 0.
- push & pop in the same cycle (JALR through $ra):
  - The top entry is replaced by push_addr.
  - Pointer and depth_count are unchanged.
  - If the stack was empty, this behaves as a push (depth_count becomes 1).
- Prediction record:
  - On an accepted pop, latch the top_addr shown that cycle plus a valid flag (0 on underflow).
  - The record is one deep; a new pop overwrites an unresolved record.
- Resolve:
  - On resolve=1 with stall=0, if the record is valid and actual_target != the recorded prediction, mispredict pulses for exactly one cycle after the edge.
  - If the record is invalid (underflow pop), mispredict also pulses.
  - Resolve clears the record.
  - resolve and pop in the same cycle: resolve compares against the old record; the new pop then writes the record.
- top_addr and top_valid are combinational from the pointer and entries.
- Latency: a push is visible on top_addr the cycle after the edge.
- overflow and mispredict are 0 in every cycle without a qualifying event, including while stall=1.
- Reset asserted mid-operation returns every output to its reset value immediately.

Test Plan:
1. Reset, then push 0x010, 0x020, 0x030 → top_addr=0x030, depth_count=3. Pop, pop → top_addr=0x010, depth_count=1.
2. Push 9 addresses 0x001..0x009 with DEPTH=8 → overflow pulses on the 9th push only. depth_count=8. Eight pops yield 0x009 down to 0x002. A 9th pop leaves depth_count=0 and top_addr=0.
3. Stack [0x100, 0x200], push&pop with push_addr=0x2FF → top_addr=0x2FF, depth_count=2. Next pop exposes 0x100.
4. Push 0x055, pop, then resolve with actual_target=0x055 → mispredict=0. Repeat with actual_target=0x056 → mispredict=1 for exactly one cycle.
5. stall=1 while push=1 and pop=1 for 3 cycles → no change to pointer, depth_count or entries. flush=1 with push=1 → depth_count=0 and top_valid=0.
6. Assert reset between clock edges with depth_count=4 → outputs clear before the next edge. After release, a pop gives top_addr=0 with no underflow state change, and a following resolve raises mispredict.

Source files
------------

// File: rtl/return_address_stack.sv
// Circular LIFO of link addresses that predicts JR $ra targets for fetch.
// Keeps a one-deep record of the last popped prediction and flags mispredicts when it resolves.
module return_address_stack #(
  parameter int ADDR_WIDTH = 11,
  parameter int DEPTH      = 8,
  parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  push,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  input  logic                  pop,
  input  logic [ADDR_WIDTH-1:0] actual_target,
  input  logic                  resolve,
  output logic [ADDR_WIDTH-1:0] top_addr,
  output logic                  top_valid,
  output logic [PTR_WIDTH:0]    depth_count,
  output logic                  overflow,
  output logic                  mispredict
);

  localparam logic [PTR_WIDTH:0]   FULL_COUNT = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH:0]   COUNT_ONE  = (PTR_WIDTH+1)'(1);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE    = PTR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] entries [DEPTH];
  logic [PTR_WIDTH-1:0]  ptr;
  logic [PTR_WIDTH-1:0]  ptr_up;
  logic [PTR_WIDTH-1:0]  ptr_down;
  logic [ADDR_WIDTH-1:0] rec_addr;
  logic                  rec_valid;
  logic                  rec_pending;

  logic active;
  logic do_flush;
  logic do_swap;
  logic do_push;
  logic do_pop;
  logic take_pop;
  logic take_resolve;
  logic is_full;
  logic rec_wrong;

  assign top_valid = (depth_count != '0);
  assign top_addr  = top_valid ? entries[ptr] : '0;
  assign ptr_up    = ptr + PTR_ONE;
  assign ptr_down  = ptr - PTR_ONE;
  assign is_full   = (depth_count == FULL_COUNT);

  // A push together with a pop on an empty stack degrades to a plain push.
  always_comb begin
    active       = !stall;
    do_flush     = active && flush;
    do_swap      = active && !flush && push && pop && top_valid;
    do_push      = active && !flush && push && !(pop && top_valid);
    do_pop       = active && !flush && pop && !push && top_valid;
    take_pop     = active && !flush && pop;
    take_resolve = active && !flush && resolve;
    rec_wrong    = !rec_valid || (actual_target != rec_addr);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr         <= '0;
      depth_count <= '0;
      overflow    <= 1'b0;
      mispredict  <= 1'b0;
      rec_addr    <= '0;
      rec_valid   <= 1'b0;
      rec_pending <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      overflow   <= do_push && is_full;
      mispredict <= take_resolve && rec_pending && rec_wrong;

      if (do_flush) begin
        ptr         <= '0;
        depth_count <= '0;
      end else if (do_swap) begin
        entries[ptr] <= push_addr;
      end else if (do_push) begin
        ptr             <= ptr_up;
        entries[ptr_up] <= push_addr;
        if (!is_full) begin
          depth_count <= depth_count + COUNT_ONE;
        end
      end else if (do_pop) begin
        ptr         <= ptr_down;
        depth_count <= depth_count - COUNT_ONE;
      end

      // A resolve in the same cycle as a pop already compared the old record above.
      if (do_flush) begin
        rec_pending <= 1'b0;
        rec_valid   <= 1'b0;
      end else if (take_pop) begin
        rec_pending <= 1'b1;
        rec_valid   <= top_valid;
        rec_addr    <= top_addr;
      end else if (take_resolve) begin
        rec_pending <= 1'b0;
        rec_valid   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_return_address_stack.sv
// Directed self-checking bench for return_address_stack with hand-computed expectations.
module tb_return_address_stack;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        push;
  logic [10:0] push_addr;
  logic        pop;
  logic [10:0] actual_target;
  logic        resolve;
  logic [10:0] top_addr;
  logic        top_valid;
  logic [3:0]  depth_count;
  logic        overflow;
  logic        mispredict;

  int check_count = 0;
  int pass_count  = 0;

  return_address_stack #(.ADDR_WIDTH(11), .DEPTH(8)) dut (
    .clock(clock),
    .reset(reset),
    .stall(stall),
    .flush(flush),
    .push(push),
    .push_addr(push_addr),
    .pop(pop),
    .actual_target(actual_target),
    .resolve(resolve),
    .top_addr(top_addr),
    .top_valid(top_valid),
    .depth_count(depth_count),
    .overflow(overflow),
    .mispredict(mispredict)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drives one cycle of controls, lets the edge happen, then returns controls to idle.
  task automatic applyStimulus(input logic st, input logic fl, input logic pu, input logic [10:0] pa,
                               input logic po, input logic [10:0] at, input logic rs);
    stall         = st;
    flush         = fl;
    push          = pu;
    push_addr     = pa;
    pop           = po;
    actual_target = at;
    resolve       = rs;
    @(posedge clock);
    #1;
    stall         = 1'b0;
    flush         = 1'b0;
    push          = 1'b0;
    push_addr     = '0;
    pop           = 1'b0;
    actual_target = '0;
    resolve       = 1'b0;
  endtask

  task automatic doPush(input logic [10:0] pa);
    applyStimulus(1'b0, 1'b0, 1'b1, pa, 1'b0, 11'h0, 1'b0);
  endtask

  task automatic doPop();
    applyStimulus(1'b0, 1'b0, 1'b0, 11'h0, 1'b1, 11'h0, 1'b0);
  endtask

  task automatic doFlush();
    applyStimulus(1'b0, 1'b1, 1'b0, 11'h0, 1'b0, 11'h0, 1'b0);
  endtask

  task automatic doResolve(input logic [10:0] at);
    applyStimulus(1'b0, 1'b0, 1'b0, 11'h0, 1'b0, at, 1'b1);
  endtask

  initial begin
    reset = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    push = 1'b0;
    push_addr = '0;
    pop = 1'b0;
    actual_target = '0;
    resolve = 1'b0;

    #3;
    checkOutput("reset_top_addr", top_addr, 0);
    checkOutput("reset_top_valid", top_valid, 0);
    checkOutput("reset_depth", depth_count, 0);
    checkOutput("reset_overflow", overflow, 0);
    checkOutput("reset_mispredict", mispredict, 0);
    #9 reset = 1'b1;

    // Basic push/pop ordering
    doPush(11'h010);
    checkOutput("t1_first_push_visible", top_addr, 11'h010);
    doPush(11'h020);
    doPush(11'h030);
    checkOutput("t1_top_after_3", top_addr, 11'h030);
    checkOutput("t1_depth_after_3", depth_count, 3);
    doPop();
    doPop();
    checkOutput("t1_top_after_pops", top_addr, 11'h010);
    checkOutput("t1_depth_after_pops", depth_count, 1);
    doFlush();
    checkOutput("t1_flush_depth", depth_count, 0);

    // Overflow wrap-around and underflow
    for (int i = 1; i <= 9; i++) begin
      doPush(11'(i));
      checkOutput($sformatf("t2_overflow_push%0d", i), overflow, (i == 9) ? 1 : 0);
    end
    checkOutput("t2_depth_full", depth_count, 8);
    for (int k = 1; k <= 8; k++) begin
      checkOutput($sformatf("t2_top_before_pop%0d", k), top_addr, 10 - k);
      doPop();
      if (k == 1) checkOutput("t2_overflow_cleared", overflow, 0);
    end
    checkOutput("t2_depth_empty", depth_count, 0);
    doPop();
    checkOutput("t2_underflow_depth", depth_count, 0);
    checkOutput("t2_underflow_top", top_addr, 0);
    checkOutput("t2_underflow_valid", top_valid, 0);
    doFlush();

    // Simultaneous push and pop replaces the top entry
    doPush(11'h100);
    doPush(11'h200);
    applyStimulus(1'b0, 1'b0, 1'b1, 11'h2FF, 1'b1, 11'h0, 1'b0);
    checkOutput("t3_swap_top", top_addr, 11'h2FF);
    checkOutput("t3_swap_depth", depth_count, 2);
    doPop();
    checkOutput("t3_pop_exposes", top_addr, 11'h100);
    doFlush();
    applyStimulus(1'b0, 1'b0, 1'b1, 11'h1AB, 1'b1, 11'h0, 1'b0);
    checkOutput("t3_swap_empty_depth", depth_count, 1);
    checkOutput("t3_swap_empty_top", top_addr, 11'h1AB);
    doFlush();

    // Prediction checking
    doPush(11'h055);
    doPop();
    checkOutput("t4_depth_after_pop", depth_count, 0);
    doResolve(11'h055);
    checkOutput("t4_correct_prediction", mispredict, 0);
    doPush(11'h055);
    doPop();
    doResolve(11'h056);
    checkOutput("t4_wrong_prediction", mispredict, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 11'h0, 1'b0, 11'h0, 1'b0);
    checkOutput("t4_mispredict_one_cycle", mispredict, 0);
    doResolve(11'h123);
    checkOutput("t4_resolve_no_record", mispredict, 0);

    // Stall freezes everything; flush beats push
    doPush(11'h0A1);
    doPush(11'h0A2);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 11'h3FF, 1'b1, 11'h0, 1'b0);
      checkOutput($sformatf("t5_stall_depth%0d", c), depth_count, 2);
      checkOutput($sformatf("t5_stall_top%0d", c), top_addr, 11'h0A2);
    end
    doPop();
    checkOutput("t5_entry_below_kept", top_addr, 11'h0A1);
    applyStimulus(1'b1, 1'b0, 1'b0, 11'h0, 1'b0, 11'h7FF, 1'b1);
    checkOutput("t5_stalled_resolve", mispredict, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 11'h0C3, 1'b0, 11'h0, 1'b0);
    checkOutput("t5_flush_push_depth", depth_count, 0);
    checkOutput("t5_flush_push_valid", top_valid, 0);
    doResolve(11'h7FF);
    checkOutput("t5_flush_drops_record", mispredict, 0);

    // Asynchronous reset mid-operation
    doPush(11'h011);
    doPush(11'h022);
    doPush(11'h033);
    doPush(11'h044);
    checkOutput("t6_depth_before_reset", depth_count, 4);
    #1 reset = 1'b0;
    #1;
    checkOutput("t6_async_depth", depth_count, 0);
    checkOutput("t6_async_top", top_addr, 0);
    checkOutput("t6_async_valid", top_valid, 0);
    #2 reset = 1'b1;
    doPop();
    checkOutput("t6_pop_top", top_addr, 0);
    checkOutput("t6_pop_depth", depth_count, 0);
    checkOutput("t6_pop_no_mispredict", mispredict, 0);
    doResolve(11'h000);
    checkOutput("t6_underflow_mispredict", mispredict, 1);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
